// File: rtl/xrog_frame_builder.sv
// rtl/xrog_frame_builder.sv - XR-BUS frame assembler/launcher; optional header stamp via XROG_SEQ_STAMP_EN
module xrog_frame_builder #(
    parameter int         FRAME_W        = 4096,
    parameter logic [3:0] REPORT_CODE    = 4'd5,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [31:0]        wr_data,
    input  logic               wr_last,
    input  logic               peer_busy,
    input  logic [3:0]         peer_state,
    output logic [FRAME_W-1:0] frame_out,
    output logic               frame_valid,
    output logic               tx_done,
    output logic               tx_error,
    output logic [15:0]        tx_count,
    output logic [2:0]         builder_state
);

    localparam int WORDS = FRAME_W / 32;
    localparam int IDX_W = $clog2(WORDS);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FILL      = 3'd1,
        S_WAIT_PEER = 3'd2,
        S_SEND      = 3'd3,
        S_HOLD      = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t             state;
    logic [FRAME_W-1:0] buffer;
    logic [IDX_W-1:0]   idx;
    logic [TMR_W-1:0]   timer;
    logic               accept;
`ifdef XROG_SEQ_STAMP_EN
    logic [7:0]         seq_cnt;
`endif

    assign accept        = wr_valid && wr_ready;
    assign frame_out     = buffer;
    assign builder_state = state;
    // Dropping valid during the peer's REPORT cycle keeps its following IDLE from re-launching.
    assign frame_valid   = ((state == S_SEND) || (state == S_HOLD)) && (peer_state != REPORT_CODE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            buffer   <= '0;
            idx      <= '0;
            timer    <= '0;
            wr_ready <= 1'b0;
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            tx_count <= '0;
`ifdef XROG_SEQ_STAMP_EN
            seq_cnt  <= '0;
`endif
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            case (state)
                S_IDLE: begin
                    wr_ready <= 1'b1;
                    if (accept) begin
                        buffer <= {{(FRAME_W-32){1'b0}}, wr_data};
                        idx    <= IDX_W'(1);
                        if (wr_last) begin
                            state    <= S_WAIT_PEER;
                            wr_ready <= 1'b0;
`ifdef XROG_SEQ_STAMP_EN
                            buffer[31:24] <= seq_cnt;
`endif
                        end else begin
                            state <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    if (accept) begin
                        buffer[{idx, 5'b0} +: 32] <= wr_data;
                        idx <= idx + IDX_W'(1);
                        // Writing the last slot closes the frame regardless of wr_last.
                        if (wr_last || (idx == LAST_IDX)) begin
                            state    <= S_WAIT_PEER;
                            wr_ready <= 1'b0;
`ifdef XROG_SEQ_STAMP_EN
                            buffer[31:24] <= seq_cnt;
`endif
                        end
                    end
                end
                S_WAIT_PEER: begin
                    if (!peer_busy && (peer_state == 4'd0)) begin
                        state <= S_SEND;
                        timer <= '0;
                    end
                end
                S_SEND: begin
                    if (timer == TMR_LAST) begin
                        state    <= S_IDLE;
                        tx_error <= 1'b1;
                        wr_ready <= 1'b1;
                        timer    <= '0;
                    end else begin
                        timer <= timer + TMR_W'(1);
                        if (peer_busy) begin
                            state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    // REPORT is tested first so a coincident timeout still completes the frame.
                    if (peer_state == REPORT_CODE) begin
                        state    <= S_DONE;
                        tx_done  <= 1'b1;
                        tx_count <= tx_count + 16'd1;
`ifdef XROG_SEQ_STAMP_EN
                        seq_cnt  <= seq_cnt + 8'd1;
`endif
                    end else if (timer == TMR_LAST) begin
                        state    <= S_IDLE;
                        tx_error <= 1'b1;
                        wr_ready <= 1'b1;
                        timer    <= '0;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    wr_ready <= 1'b1;
                end
                default: begin
                    state    <= S_IDLE;
                    wr_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xrog_frame_builder.sv
// tb/tb_xrog_frame_builder.sv - scoreboard bench for xrog_frame_builder
module tb_xrog_frame_builder;

    localparam int         FW  = 4096;
    localparam int         NW  = FW / 32;
    localparam int         TO  = 16;
    localparam logic [3:0] RPT = 4'd5;

    typedef struct {
        logic [FW-1:0] frame;
        logic          err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [31:0]   wr_data = '0;
    logic          wr_last = 1'b0;
    logic          peer_busy = 1'b0;
    logic [3:0]    peer_state = '0;
    logic [FW-1:0] frame_out;
    logic          frame_valid;
    logic          tx_done;
    logic          tx_error;
    logic [15:0]   tx_count;
    logic [2:0]    builder_state;

    int            vectors = 0;
    int            miscompares = 0;
    int            mdl_count = 0;
`ifdef XROG_SEQ_STAMP_EN
    int            mdl_seq = 0;
`endif
    logic [31:0]   words [NW];
    exp_t          sb [$];

    xrog_frame_builder #(
        .FRAME_W       (FW),
        .REPORT_CODE   (RPT),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .wr_last      (wr_last),
        .peer_busy    (peer_busy),
        .peer_state   (peer_state),
        .frame_out    (frame_out),
        .frame_valid  (frame_valid),
        .tx_done      (tx_done),
        .tx_error     (tx_error),
        .tx_count     (tx_count),
        .builder_state(builder_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Completion monitor: every tx_done/tx_error retires the oldest expected frame.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (tx_done || tx_error)) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("kind_error", {31'd0, tx_error}, {31'd0, e.err});
                check("kind_done", {31'd0, tx_done}, {31'd0, !e.err});
                if (!e.err) begin
                    mdl_count = (mdl_count + 1) & 16'hFFFF;
`ifdef XROG_SEQ_STAMP_EN
                    mdl_seq = (mdl_seq + 1) & 8'hFF;
`endif
                end
                check("tx_count", {16'd0, tx_count}, mdl_count);
                for (int i = 0; i < NW; i++)
                    check($sformatf("frame_w%0d", i), frame_out[32*i +: 32], e.frame[32*i +: 32]);
            end
        end
    end

    task automatic push_word(input logic [31:0] d, input logic last);
        int k;
        wr_data  = d;
        wr_last  = last;
        wr_valid = 1'b1;
        for (k = 0; k < 50 && !wr_ready; k++) @(negedge clk);
        if (!wr_ready) check("wr_ready_timeout", {31'd0, wr_ready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int n, input logic use_last, input logic err);
        exp_t e;
        e.frame = '0;
        for (int i = 0; i < n; i++) begin
            push_word(words[i], use_last && (i == n - 1));
            e.frame[32*i +: 32] = words[i];
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
`ifdef XROG_SEQ_STAMP_EN
        e.frame[31:24] = mdl_seq[7:0];
`endif
        e.err = err;
        sb.push_back(e);
        check("close_state", {29'd0, builder_state}, 32'd2);
        check("close_ready", {31'd0, wr_ready}, 32'd0);
    endtask

    task automatic run_peer(input int idle_cycles, input int busy_cycles);
        peer_busy  = 1'b0;
        peer_state = 4'd0;
        @(posedge clk); #1;
        check("send_state", {29'd0, builder_state}, 32'd3);
        check("send_valid", {31'd0, frame_valid}, 32'd1);
        check("send_ready", {31'd0, wr_ready}, 32'd0);
        repeat (idle_cycles - 1) begin @(posedge clk); #1; end
        peer_busy  = 1'b1;
        peer_state = 4'd1;
        @(posedge clk); #1;
        check("hold_state", {29'd0, builder_state}, 32'd4);
        check("hold_valid", {31'd0, frame_valid}, 32'd1);
        repeat (busy_cycles) begin peer_state = 4'd2; @(posedge clk); #1; end
        peer_state = RPT;
        #1;
        check("report_valid", {31'd0, frame_valid}, 32'd0);
        check("report_ready", {31'd0, wr_ready}, 32'd0);
        @(posedge clk); #1;
        check("done_state", {29'd0, builder_state}, 32'd5);
        check("done_pulse", {31'd0, tx_done}, 32'd1);
        peer_busy  = 1'b0;
        peer_state = 4'd0;
        @(posedge clk); #1;
        check("idle_state", {29'd0, builder_state}, 32'd0);
        check("idle_ready", {31'd0, wr_ready}, 32'd1);
        check("done_clear", {31'd0, tx_done}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] stamp_exp;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, wr_ready}, 32'd0);
        check("rst_valid", {31'd0, frame_valid}, 32'd0);
        check("rst_state", {29'd0, builder_state}, 32'd0);
        check("rst_count", {16'd0, tx_count}, 32'd0);
        check("rst_pulses", {30'd0, tx_done, tx_error}, 32'd0);
        check("rst_frame_w0", frame_out[31:0], 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", {31'd0, wr_ready}, 32'd1);

        // Full frame, forced close on slot 127.
        for (int k = 0; k < NW; k++) words[k] = k;
        send_frame(NW, 1'b0, 1'b0);
        run_peer(3, 1);

        // Short frame closed by wr_last; upper slots must stay zero.
        words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
        send_frame(3, 1'b1, 1'b0);
        run_peer(2, 2);

        // Peer busy when the frame closes.
        peer_busy  = 1'b1;
        peer_state = 4'd3;
        for (int k = 0; k < 5; k++) words[k] = $urandom;
        send_frame(5, 1'b1, 1'b0);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("wait_state", {29'd0, builder_state}, 32'd2);
            check("wait_valid", {31'd0, frame_valid}, 32'd0);
        end
        run_peer(1, 0);

        // Timeout: peer never responds.
        for (int k = 0; k < 4; k++) words[k] = 32'hC0DE_0000 + k;
        send_frame(4, 1'b1, 1'b1);
        @(posedge clk); #1;
        check("to_send_state", {29'd0, builder_state}, 32'd3);
        for (int c = 1; c < TO; c++) begin
            @(posedge clk); #1;
            check("to_no_error", {31'd0, tx_error}, 32'd0);
        end
        @(posedge clk); #1;
        check("to_error", {31'd0, tx_error}, 32'd1);
        check("to_state", {29'd0, builder_state}, 32'd0);
        check("to_valid", {31'd0, frame_valid}, 32'd0);
        check("to_count", {16'd0, tx_count}, 32'd3);
        @(posedge clk); #1;
        check("to_error_clear", {31'd0, tx_error}, 32'd0);

        // New frame accepted after a timeout.
        words[0] = 32'hDEAD_BEEF; words[1] = 32'h0123_4567;
        send_frame(2, 1'b1, 1'b0);
        run_peer(1, 1);
        check("count_after_to", {16'd0, tx_count}, 32'd4);

        // Asynchronous reset while in HOLD.
        for (int k = 0; k < 3; k++) words[k] = 32'h5A5A_0000 + k;
        send_frame(3, 1'b1, 1'b0);
        @(posedge clk); #1;
        peer_busy  = 1'b1;
        peer_state = 4'd1;
        @(posedge clk); #1;
        check("ar_hold_state", {29'd0, builder_state}, 32'd4);
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_valid", {31'd0, frame_valid}, 32'd0);
        check("ar_state", {29'd0, builder_state}, 32'd0);
        check("ar_count", {16'd0, tx_count}, 32'd0);
        sb.delete();
        mdl_count = 0;
`ifdef XROG_SEQ_STAMP_EN
        mdl_seq = 0;
`endif
        peer_busy  = 1'b0;
        peer_state = 4'd0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Header byte handling over three frames.
        for (int f = 0; f < 3; f++) begin
            words[0] = 32'hAA12_3456;
            words[1] = 32'h0000_0F00 + f;
            send_frame(2, 1'b1, 1'b0);
`ifdef XROG_SEQ_STAMP_EN
            stamp_exp = 8'(f);
`else
            stamp_exp = 8'hAA;
`endif
            check("header_byte", {24'd0, frame_out[31:24]}, {24'd0, stamp_exp});
            run_peer(1, 1);
        end
        check("final_count", {16'd0, tx_count}, 32'd3);
        check("sb_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
